// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default parameters for the skid-margin FIFO.
package fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_FIFO_DEPTH = 32;
    localparam int unsigned DEF_FIFO_SKID  = 4;

    // Bits needed to hold a count in 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned addr_width(input int unsigned depth);
        int unsigned w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port and one registered read port with read enable.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_FIFO_DEPTH,
    parameter int unsigned ADDR_WIDTH = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the read register is reset, so the output never shows X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_skid_ctl.sv
// Valid/ready FIFO with early-throttled write ready (skid margin) and registered output stage.
// Optional sticky overflow detection is built when FIFO_OVERFLOW_DET_EN is defined.
module fifo_skid_ctl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned FIFO_SKID  = DEF_FIFO_SKID,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic                                 clkIn,
    input  logic                                 rstNIn,
    input  logic                                 flushIn,
    input  logic [DATA_WIDTH-1:0]                wrDataIn,
    input  logic                                 wrValidIn,
    output logic                                 wrReadyOut,
    output logic [DATA_WIDTH-1:0]                rdDataOut,
    output logic                                 rdValidOut,
    input  logic                                 rdReadyIn,
    output logic [count_width(FIFO_DEPTH)-1:0]   levelOut,
    output logic                                 almostEmptyOut,
    output logic                                 overflowOut,
    input  logic                                 errClearIn
);

    localparam int unsigned CW = count_width(FIFO_DEPTH);
    localparam int unsigned AW = addr_width(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_LVL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] READY_LVL = CW'(FIFO_DEPTH - FIFO_SKID);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FIFO_DEPTH - 1);

    logic [CW-1:0] level_q, level_d, ram_count;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          valid_q, valid_d;
    logic          ready_q, ready_d;
    logic          push, pop, load;

    always_comb begin
        pop       = valid_q && rdReadyIn;
        push      = wrValidIn && ((level_q != FULL_LVL) || pop);
        // Words sitting in RAM, i.e. not yet moved into the output register.
        ram_count = level_q - CW'(valid_q);
        load      = (ram_count != '0) && (!valid_q || pop);

        level_d  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;

        if (flushIn) begin
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            valid_d  = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + AW'(1);
            end
            if (load) begin
                rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                level_d = level_q + CW'(1);
            end else if (pop && !push) begin
                level_d = level_q - CW'(1);
            end
            if (load) begin
                valid_d = 1'b1;
            end else if (pop) begin
                valid_d = 1'b0;
            end
        end

        ready_d = (level_d <= READY_LVL);
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk     (clkIn),
        .rst_n   (rstNIn),
        .wr_en   (push && !flushIn),
        .wr_addr (wr_ptr_q),
        .wr_data (wrDataIn),
        .rd_en   (load && !flushIn),
        .rd_addr (rd_ptr_q),
        .rd_data (rdDataOut)
    );

    assign wrReadyOut     = ready_q;
    assign rdValidOut     = valid_q;
    assign levelOut       = level_q;
    assign almostEmptyOut = (32'(level_q) <= AE_THRESH);

`ifdef FIFO_OVERFLOW_DET_EN
    logic drop, ovf_q;

    // A write during flush is discarded by the flush, not counted as a drop.
    assign drop = wrValidIn && !flushIn && (level_q == FULL_LVL) && !pop;

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (errClearIn) begin
            ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clkIn) begin
        if (rstNIn && drop) begin
            $error("fifo_skid_ctl: push dropped, FIFO full");
        end
    end

    assign overflowOut = ovf_q;
`else
    logic unused_err_clear;
    assign unused_err_clear = errClearIn;
    assign overflowOut      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_skid_ctl.sv
// Self-checking bench: two FIFO instances (depth 32 and depth 5) against a queue-level model.
module tb_fifo_skid_ctl;

    localparam int DW = 32;
    localparam int D0 = 32;
    localparam int S0 = 4;
    localparam int A0 = 1;
    localparam int D1 = 5;
    localparam int S1 = 2;
    localparam int A1 = 2;
`ifdef FIFO_OVERFLOW_DET_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          flush [2];
    logic          wr_valid [2];
    logic          rd_ready [2];
    logic          err_clr [2];
    logic [DW-1:0] wr_data [2];
    logic [DW-1:0] rd_data [2];
    logic          rd_valid [2];
    logic          wr_ready [2];
    logic          ae [2];
    logic          ovf [2];
    logic [5:0]    lvl0;
    logic [2:0]    lvl1;

    fifo_skid_ctl #(.DATA_WIDTH(DW), .FIFO_DEPTH(D0), .FIFO_SKID(S0), .AE_THRESH(A0)) dut0 (
        .clkIn(clk), .rstNIn(rst_n), .flushIn(flush[0]), .wrDataIn(wr_data[0]),
        .wrValidIn(wr_valid[0]), .wrReadyOut(wr_ready[0]), .rdDataOut(rd_data[0]),
        .rdValidOut(rd_valid[0]), .rdReadyIn(rd_ready[0]), .levelOut(lvl0),
        .almostEmptyOut(ae[0]), .overflowOut(ovf[0]), .errClearIn(err_clr[0])
    );

    fifo_skid_ctl #(.DATA_WIDTH(DW), .FIFO_DEPTH(D1), .FIFO_SKID(S1), .AE_THRESH(A1)) dut1 (
        .clkIn(clk), .rstNIn(rst_n), .flushIn(flush[1]), .wrDataIn(wr_data[1]),
        .wrValidIn(wr_valid[1]), .wrReadyOut(wr_ready[1]), .rdDataOut(rd_data[1]),
        .rdValidOut(rd_valid[1]), .rdReadyIn(rd_ready[1]), .levelOut(lvl1),
        .almostEmptyOut(ae[1]), .overflowOut(ovf[1]), .errClearIn(err_clr[1])
    );

    // Model: a circular list of stored words, each stamped with the edge that accepted it.
    int            depth [2] = '{D0, D1};
    int            skid [2]  = '{S0, S1};
    int            aeth [2]  = '{A0, A1};
    logic [DW-1:0] mdata [2][64];
    int            medge [2][64];
    int            mhead [2];
    int            msize [2];
    bit            movf [2];
    bit            did_push [2];
    int            edge_n = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
        end
    endtask

    // The head word is visible once at least one edge has passed since it was accepted.
    function automatic bit m_valid(input int s);
        return (msize[s] > 0) && (medge[s][mhead[s]] < edge_n);
    endfunction

    function automatic logic [63:0] level_of(input int s);
        return (s == 0) ? 64'(lvl0) : 64'(lvl1);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            msize[s] = 0;
            mhead[s] = 0;
            movf[s]  = 1'b0;
        end
    endtask

    task automatic check_outputs(input int s);
        check_eq($sformatf("d%0d.level", s), level_of(s), 64'(msize[s]));
        check_eq($sformatf("d%0d.rd_valid", s), 64'(rd_valid[s]), 64'(m_valid(s)));
        check_eq($sformatf("d%0d.wr_ready", s), 64'(wr_ready[s]),
                 64'(msize[s] <= depth[s] - skid[s]));
        check_eq($sformatf("d%0d.almost_empty", s), 64'(ae[s]), 64'(msize[s] <= aeth[s]));
        check_eq($sformatf("d%0d.overflow", s), 64'(ovf[s]), 64'(movf[s]));
        if (m_valid(s)) begin
            check_eq($sformatf("d%0d.rd_data", s), 64'(rd_data[s]), 64'(mdata[s][mhead[s]]));
        end
    endtask

    task automatic check_reset(input int s);
        check_eq($sformatf("d%0d.rst_level", s), level_of(s), 64'd0);
        check_eq($sformatf("d%0d.rst_valid", s), 64'(rd_valid[s]), 64'd0);
        check_eq($sformatf("d%0d.rst_data", s), 64'(rd_data[s]), 64'd0);
        check_eq($sformatf("d%0d.rst_ready", s), 64'(wr_ready[s]), 64'd0);
        check_eq($sformatf("d%0d.rst_ae", s), 64'(ae[s]), 64'd1);
        check_eq($sformatf("d%0d.rst_ovf", s), 64'(ovf[s]), 64'd0);
    endtask

    task automatic tick();
        bit push [2];
        bit pop [2];
        bit drop [2];
        for (int s = 0; s < 2; s++) begin
            pop[s]  = m_valid(s) && rd_ready[s];
            push[s] = wr_valid[s] && ((msize[s] < depth[s]) || pop[s]);
            drop[s] = wr_valid[s] && !flush[s] && (msize[s] == depth[s]) && !pop[s];
        end
        @(posedge clk);
        edge_n++;
        for (int s = 0; s < 2; s++) begin
            did_push[s] = 1'b0;
            if (flush[s]) begin
                msize[s] = 0;
                mhead[s] = 0;
            end else begin
                if (pop[s]) begin
                    mhead[s] = (mhead[s] + 1) % 64;
                    msize[s]--;
                end
                if (push[s]) begin
                    mdata[s][(mhead[s] + msize[s]) % 64] = wr_data[s];
                    medge[s][(mhead[s] + msize[s]) % 64] = edge_n;
                    msize[s]++;
                    did_push[s] = 1'b1;
                end
            end
            if (OVF_EN && drop[s]) begin
                movf[s] = 1'b1;
            end else if (err_clr[s]) begin
                movf[s] = 1'b0;
            end
        end
        #1;
        for (int s = 0; s < 2; s++) begin
            check_outputs(s);
        end
    endtask

    task automatic push_words(input int s, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            wr_valid[s] = 1'b1;
            wr_data[s]  = DW'(base + i);
            tick();
        end
        wr_valid[s] = 1'b0;
    endtask

    // Pops until empty; when first >= 0 the head words must count up from first.
    task automatic drain(input int s, input int first);
        int want = first;
        int guard = 0;
        rd_ready[s] = 1'b1;
        while (msize[s] > 0 && guard < 200) begin
            if (first >= 0 && m_valid(s)) begin
                check_eq("drain.order", 64'(rd_data[s]), 64'(want));
                want++;
            end
            tick();
            guard++;
        end
        rd_ready[s] = 1'b0;
        check_eq("drain.empty", level_of(s), 64'd0);
    endtask

    task automatic single_word();
        wr_valid[0] = 1'b1;
        wr_data[0]  = 32'h5A;
        tick();
        wr_valid[0] = 1'b0;
        check_eq("single.level_e", level_of(0), 64'd1);
        check_eq("single.valid_e", 64'(rd_valid[0]), 64'd0);
        tick();
        check_eq("single.valid_e1", 64'(rd_valid[0]), 64'd1);
        check_eq("single.data_e1", 64'(rd_data[0]), 64'h5A);
        rd_ready[0] = 1'b1;
        tick();
        rd_ready[0] = 1'b0;
        check_eq("single.level_pop", level_of(0), 64'd0);
        check_eq("single.valid_pop", 64'(rd_valid[0]), 64'd0);
        check_eq("single.ae_pop", 64'(ae[0]), 64'd1);
    endtask

    initial begin
        int next_in;
        int next_out;
        for (int s = 0; s < 2; s++) begin
            flush[s]    = 1'b0;
            wr_valid[s] = 1'b0;
            rd_ready[s] = 1'b0;
            err_clr[s]  = 1'b0;
            wr_data[s]  = '0;
        end
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check_reset(0);
        check_reset(1);
        #6 rst_n = 1'b1;
        tick();

        // Fill depth-32 FIFO with 1..32, then push one word too many.
        push_words(0, 32, 1);
        check_eq("fill.level", level_of(0), 64'd32);
        wr_valid[0] = 1'b1;
        wr_data[0]  = 32'hDEAD;
        tick();
        wr_valid[0] = 1'b0;
        check_eq("ovf.level", level_of(0), 64'd32);
        check_eq("ovf.flag", 64'(ovf[0]), 64'(OVF_EN));
        err_clr[0] = 1'b1;
        tick();
        err_clr[0] = 1'b0;
        drain(0, 1);

        single_word();

        // Flush at level 10 with a simultaneous push and pop.
        push_words(0, 10, 100);
        flush[0]    = 1'b1;
        wr_valid[0] = 1'b1;
        wr_data[0]  = 32'hBAD;
        rd_ready[0] = 1'b1;
        tick();
        flush[0]    = 1'b0;
        wr_valid[0] = 1'b0;
        rd_ready[0] = 1'b0;
        check_eq("flush.level", level_of(0), 64'd0);
        check_eq("flush.valid", 64'(rd_valid[0]), 64'd0);
        check_eq("flush.ready", 64'(wr_ready[0]), 64'd1);
        push_words(0, 1, 32'h77);
        tick();
        check_eq("flush.next_data", 64'(rd_data[0]), 64'h77);
        drain(0, 32'h77);

        // Asynchronous reset between edges at level 7.
        push_words(0, 7, 200);
        #2 rst_n = 1'b0;
        #1;
        check_reset(0);
        check_reset(1);
        model_reset();
        #1 rst_n = 1'b1;
        tick();
        single_word();

        // Depth-5 FIFO: 100 words with random valid/ready.
        next_in  = 0;
        next_out = 0;
        for (int c = 0; c < 3000 && next_out < 100; c++) begin
            wr_valid[1] = (next_in < 100) && ($urandom_range(0, 1) == 1) && (msize[1] < D1);
            wr_data[1]  = DW'(next_in);
            rd_ready[1] = ($urandom_range(0, 1) == 1);
            if (m_valid(1) && rd_ready[1]) begin
                check_eq("stream.order", 64'(rd_data[1]), 64'(next_out));
                next_out++;
            end
            tick();
            if (did_push[1]) begin
                next_in++;
            end
        end
        wr_valid[1] = 1'b0;
        rd_ready[1] = 1'b0;
        check_eq("stream.count", 64'(next_out), 64'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_skid_ctl.md
Name: fifo_skid_ctl

Overview:
- Parametrised successor to the team's single-width valid/ready FIFO.
- Configurable data width, depth and skid allowance; non-power-of-two depth; synchronous flush; occupancy/almost-empty status.
- Sits between streaming producers and consumers in the accelerator datapath, e.g. DMA-to-compute and compute-to-writeback.
- Skid margin lets a pipelined producer keep issuing SKID words after wrReadyOut falls without loss.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- FIFO_DEPTH, 32, total word capacity including output stage; any value >= 2, need not be a power of two.
- FIFO_SKID, 4, words still accepted after wrReadyOut deasserts; 0 <= FIFO_SKID < FIFO_DEPTH.
- AE_THRESH, 1, almostEmptyOut asserts when level <= AE_THRESH.

Ports:
- clkIn  in  1  single clock, rising edge
- rstNIn  in  1  reset, asynchronous assert, active-low
- flushIn  in  1  synchronous flush, discards all contents
- wrDataIn  in  DATA_WIDTH  write data
- wrValidIn  in  1  write request
- wrReadyOut  out  1  write-ready, throttled early by FIFO_SKID
- rdDataOut  out  DATA_WIDTH  head word, registered
- rdValidOut  out  1  head word valid
- rdReadyIn  in  1  consumer accepts head word
- levelOut  out  clog2(FIFO_DEPTH+1)  words accepted and not yet popped
- almostEmptyOut  out  1  levelOut <= AE_THRESH
- overflowOut  out  1  sticky overflow flag (optional feature)
- errClearIn  in  1  clears overflowOut (optional feature)

Behaviour:
- Reset (rstNIn low), asynchronous, all outputs:
  - wrReadyOut=0, rdValidOut=0, rdDataOut=0, levelOut=0, almostEmptyOut=1, overflowOut=0.
  - Pointers cleared.
  - wrReadyOut rises on the first clkIn edge after release.
  - Reset mid-transfer discards all contents immediately.
- Push: wrValidIn=1 at an edge with level<FIFO_DEPTH (or level==FIFO_DEPTH with a pop at the same edge).
  - wrReadyOut is NOT a push condition.
  - levelOut increments after that edge.
- wrReadyOut registered: 1 iff next level <= FIFO_DEPTH-FIFO_SKID.
  - Example: DEPTH=32, SKID=4 -> ready while level <= 28.
  - Writes while wrReadyOut=0 are accepted until level==FIFO_DEPTH.
- Overflow: wrValidIn=1 at level==FIFO_DEPTH with no simultaneous pop -> word dropped; level and contents unchanged.
- Pop: rdValidOut && rdReadyIn at an edge.
  - levelOut decrements after that edge.
  - rdReadyIn while rdValidOut=0 is ignored.
- Latency: word pushed at edge E into an empty FIFO -> rdValidOut=1 and rdDataOut valid after edge E+1. levelOut already counts it after edge E.
- Throughput: 1 push and 1 pop per cycle sustained, no bubbles while data is stored.
  - rdDataOut holds stable while rdValidOut=1 and rdReadyIn=0.
- Simultaneous push+pop: level unchanged, including at full and at level==1.
  - If level==1 at push+pop and the popped word leaves, rdValidOut=0 for one cycle (latency rule), then 1.
- Wrap: read/write addresses wrap from FIFO_DEPTH-1 to 0 by explicit compare, never by bit truncation.
- Flush: at the next edge, level=0, rdValidOut=0, pointers reset.
  - A push or pop in the same cycle as flush is discarded.
  - wrReadyOut=1 after that edge.
  - Flush does not clear overflowOut.
- Data ordering strictly FIFO; rdDataOut is don't-care when rdValidOut=0 but must not glitch X out of reset.

Optional Feature:
- Macro FIFO_OVERFLOW_DET_EN.
- Defined:
  - overflowOut sets at the edge after any dropped push and stays 1 until errClearIn=1 at an edge.
  - If set and clear coincide, set wins.
  - A simulation-only $error is emitted on each drop.
- Undefined: overflowOut tied 0, errClearIn ignored, dropped pushes silent; no overflow logic synthesised.

Decomposition:
- Package fifo_pkg:
  - function count_width(depth) = clog2(depth+1).
  - function addr_width(depth) = max(1, clog2(depth)).
  - Localparam defaults DEF_DATA_WIDTH=32, DEF_FIFO_DEPTH=32, DEF_FIFO_SKID=4.
- Sub-module fifo_ram: simple dual-port, DATA_WIDTH x depth, one write port, one registered read port, no reset on storage.
- fifo_skid_ctl holds pointers, level counter, ready/flush/overflow logic and the output prefetch stage.

Test Plan:
- DEPTH=32, SKID=4: write 1..32 back-to-back, no reads -> wrReadyOut=1 through level 28, 0 from level 29; levelOut=32; all 32 accepted; overflowOut=0.
- Fill to 32, push 0xDEAD -> dropped; levelOut stays 32; overflowOut=1 (macro on) / 0 (off); then pop all -> data 1..32 in order, 0xDEAD never appears.
- Empty FIFO, single push 0x5A at edge E -> levelOut=1 after E; rdValidOut=0 after E, 1 after E+1; pop -> levelOut=0, rdValidOut=0, almostEmptyOut=1.
- DEPTH=5 (non-power-of-two): 100 words streamed with random wrValidIn/rdReadyIn -> output sequence equals input 0..99; levelOut never exceeds 5; addresses wrap.
- Level 10, flushIn=1 with simultaneous push and pop -> next cycle levelOut=0, rdValidOut=0, wrReadyOut=1; next push 0x77 is the next word read.
- Assert rstNIn=0 mid-stream, level 7, between edges -> outputs reach reset values immediately without a clock edge; after release, empty FIFO behaviour as in scenario 3.
